fb_pixel_packer: RTL and testbench



---
 rtl/fb_pkg.sv | 18 +
 rtl/fb_word_addr_counter.sv | 46 ++++
 rtl/fb_pixel_packer.sv | 175 +++++++++++++++++
 tb/tb_fb_pixel_packer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer pixel packer.
package fb_pkg;

  localparam int unsigned FB_H      = 32'd640;
  localparam int unsigned FB_V      = 32'd480;
  localparam int unsigned FB_WORDS  = FB_H * FB_V / 32'd32;
  localparam int unsigned FB_ADDR_W = 32'd15;

  typedef enum logic [1:0] {
    PACK  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } fb_pack_state_t;

  typedef logic [31:0]          pixel_word_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

endpackage

// File: rtl/fb_word_addr_counter.sv
// Word index counter shared by the pack and clear paths; wraps after WORDS-1.
module fb_word_addr_counter
  import fb_pkg::*;
#(
  parameter int unsigned WORDS = FB_WORDS
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     clr,
  input  logic     en,
  output fb_addr_t idx
);

  localparam fb_addr_t LAST = fb_addr_t'(WORDS - 32'd1);

  fb_addr_t idx_r;
  fb_addr_t base_s;
  fb_addr_t idx_nxt_s;

  // clr restarts from zero; en then advances from that base in the same cycle
  always_comb begin
    base_s    = clr ? 15'd0 : idx_r;
    idx_nxt_s = base_s;
    if (en) begin
      if (base_s == LAST) begin
        idx_nxt_s = 15'd0;
      end else begin
        idx_nxt_s = base_s + 15'd1;
      end
    end else begin
      idx_nxt_s = base_s;
    end
  end

  // Index register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_r <= 15'd0;
    end else begin
      idx_r <= idx_nxt_s;
    end
  end

  assign idx = idx_r;

endmodule

// File: rtl/fb_pixel_packer.sv
// Packs a raster stream of 1-bit pixels into 32-bit framebuffer words and runs a full-frame clear.
// Optional FB_FRAME_CNT_EN adds a frame_count output counting packed frames.
module fb_pixel_packer
  import fb_pkg::*;
#(
  parameter int unsigned H_PIXELS   = FB_H,
  parameter int unsigned V_PIXELS   = FB_V,
  parameter fb_addr_t    BASE_ADDR  = 15'd0,
  parameter pixel_word_t CLEAR_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_valid,
  input  logic        pix_data,
  input  logic        pix_sof,
  output logic        pix_ready,
  input  logic        clear_req,
  output logic        busy,
  output logic        clear_done,
  output pixel_word_t fb_writedata,
  output logic        fb_write,
  output fb_addr_t    fb_address
`ifdef FB_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int unsigned WORDS = H_PIXELS * V_PIXELS / 32'd32;

  fb_pack_state_t state_r, state_nxt_s;
  logic [4:0]     bit_idx_r, bit_idx_nxt_s;
  pixel_word_t    shift_r, shift_nxt_s;
  fb_addr_t       word_idx_s;
  logic           cnt_clr_s, cnt_en_s, accept_s;
  logic           fb_write_r, write_nxt_s;
  pixel_word_t    fb_writedata_r, data_nxt_s;
  fb_addr_t       fb_address_r, addr_nxt_s;
  logic           busy_r, busy_nxt_s;
  logic           clear_done_r, done_nxt_s;

  assign pix_ready = reset_n && (state_r == PACK) && !clear_req;
  assign accept_s  = pix_valid && pix_ready;

  fb_word_addr_counter #(.WORDS(WORDS)) u_word_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr_s),
    .en      (cnt_en_s),
    .idx     (word_idx_s)
  );

  // Next-state, packing and clear-engine decode
  always_comb begin
    state_nxt_s   = state_r;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    write_nxt_s   = 1'b0;
    data_nxt_s    = fb_writedata_r;
    addr_nxt_s    = fb_address_r;
    busy_nxt_s    = busy_r;
    done_nxt_s    = 1'b0;
    cnt_clr_s     = 1'b0;
    cnt_en_s      = 1'b0;
    case (state_r)
      PACK: begin
        busy_nxt_s = 1'b0;
        if (clear_req) begin
          // First clear write is issued on the request edge so it follows any pending pixel word directly
          state_nxt_s   = CLEAR;
          bit_idx_nxt_s = 5'd0;
          shift_nxt_s   = 32'h0000_0000;
          busy_nxt_s    = 1'b1;
          cnt_clr_s     = 1'b1;
          cnt_en_s      = 1'b1;
          write_nxt_s   = 1'b1;
          data_nxt_s    = CLEAR_WORD;
          addr_nxt_s    = BASE_ADDR;
        end else if (accept_s) begin
          if (pix_sof) begin
            cnt_clr_s     = 1'b1;
            shift_nxt_s   = {31'h0000_0000, pix_data};
            bit_idx_nxt_s = 5'd1;
          end else begin
            shift_nxt_s[bit_idx_r] = pix_data;
            bit_idx_nxt_s          = bit_idx_r + 5'd1;
            if (bit_idx_r == 5'd31) begin
              write_nxt_s = 1'b1;
              data_nxt_s  = shift_nxt_s;
              addr_nxt_s  = BASE_ADDR + word_idx_s;
              cnt_en_s    = 1'b1;
            end else begin
              write_nxt_s = 1'b0;
            end
          end
        end else begin
          state_nxt_s = PACK;
        end
      end
      CLEAR: begin
        // Index wraps to zero once the last word has been registered
        if (word_idx_s == 15'd0) begin
          state_nxt_s = DONE;
          done_nxt_s  = 1'b1;
        end else begin
          write_nxt_s = 1'b1;
          data_nxt_s  = CLEAR_WORD;
          addr_nxt_s  = BASE_ADDR + word_idx_s;
          cnt_en_s    = 1'b1;
        end
      end
      DONE: begin
        state_nxt_s = PACK;
        busy_nxt_s  = 1'b0;
      end
      default: begin
        state_nxt_s = PACK;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, shift register and registered write-port outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r        <= PACK;
      bit_idx_r      <= 5'd0;
      shift_r        <= 32'h0000_0000;
      fb_write_r     <= 1'b0;
      fb_writedata_r <= 32'h0000_0000;
      fb_address_r   <= BASE_ADDR;
      busy_r         <= 1'b0;
      clear_done_r   <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      bit_idx_r      <= bit_idx_nxt_s;
      shift_r        <= shift_nxt_s;
      fb_write_r     <= write_nxt_s;
      fb_writedata_r <= data_nxt_s;
      fb_address_r   <= addr_nxt_s;
      busy_r         <= busy_nxt_s;
      clear_done_r   <= done_nxt_s;
    end
  end

  assign fb_write     = fb_write_r;
  assign fb_writedata = fb_writedata_r;
  assign fb_address   = fb_address_r;
  assign busy         = busy_r;
  assign clear_done   = clear_done_r;

`ifdef FB_FRAME_CNT_EN
  localparam fb_addr_t LAST_WORD = fb_addr_t'(WORDS - 32'd1);

  logic [15:0] frame_count_r;
  logic        frame_last_s;

  assign frame_last_s = (state_r == PACK) && accept_s && !pix_sof &&
                        (bit_idx_r == 5'd31) && (word_idx_s == LAST_WORD);

  // Counts frames completed by the packer; clear writes never reach this
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_count_r <= 16'd0;
    end else if (frame_last_s) begin
      frame_count_r <= frame_count_r + 16'd1;
    end else begin
      frame_count_r <= frame_count_r;
    end
  end

  assign frame_count = frame_count_r;
`endif

endmodule

// File: tb/tb_fb_pixel_packer.sv
// Self-checking bench for fb_pixel_packer on a reduced 64x16 frame (32 words).
module tb_fb_pixel_packer;

  localparam int unsigned H     = 64;
  localparam int unsigned V     = 16;
  localparam int unsigned WORDS = H * V / 32;
  localparam logic [14:0] BASE  = 15'd2000;
  localparam logic [31:0] CLR   = 32'hC3A5_5A3C;

  typedef struct packed {
    logic [14:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } wr_t;

  logic clk = 1'b0, reset_n = 1'b0;
  logic pix_valid = 1'b0, pix_data = 1'b0, pix_sof = 1'b0, clear_req = 1'b0;
  logic pix_ready, busy, clear_done, fb_write;
  logic [31:0] fb_writedata;
  logic [14:0] fb_address;
`ifdef FB_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  int unsigned cyc = 0;
  int errors = 0, checks = 0;
  wr_t exp_q[$], obs_q[$];
  int unsigned exp_done[$], obs_done[$];
  wr_t e, o;
  logic [31:0] m_bits = 32'h0;
  int unsigned m_count = 0, m_word = 0;

  fb_pixel_packer #(.H_PIXELS(H), .V_PIXELS(V), .BASE_ADDR(BASE), .CLEAR_WORD(CLR)) dut (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_ready(pix_ready), .clear_req(clear_req), .busy(busy),
    .clear_done(clear_done), .fb_writedata(fb_writedata), .fb_write(fb_write),
    .fb_address(fb_address)
`ifdef FB_FRAME_CNT_EN
    , .frame_count(frame_count)
`endif
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fb_write === 1'b1) obs_q.push_back('{addr: fb_address, data: fb_writedata, cyc: cyc});
    if (clear_done === 1'b1) obs_done.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: a pixel buffer filled left to right, emitted once 32 pixels are collected.
  task automatic model_pixel(input logic d, input logic sof, input int unsigned acc);
    if (sof) begin m_count = 0; m_word = 0; end
    m_bits[m_count] = d;
    m_count++;
    if (m_count == 32) begin
      exp_q.push_back('{addr: 15'(BASE + m_word), data: m_bits, cyc: acc});
      m_word = (m_word + 1) % WORDS;
      m_count = 0;
    end
  endtask

  task automatic model_clear(input int unsigned req);
    for (int i = 0; i < WORDS; i++) exp_q.push_back('{addr: 15'(BASE + i), data: CLR, cyc: req + i});
    exp_done.push_back(req + WORDS);
    m_count = 0;
    m_word = 0;
  endtask

  task automatic send_pixel(input logic d, input logic sof, input bit gaps);
    if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
    pix_valid = 1'b1; pix_data = d; pix_sof = sof;
    model_pixel(d, sof, cyc + 1);
    @(negedge clk);
    pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    idle(3);
    checks++;
    if ({fb_write, busy, clear_done, pix_ready} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b expected 0000", {fb_write, busy, clear_done, pix_ready});
    end
    checks++;
    if (fb_address !== BASE || fb_writedata !== 32'h0) begin
      errors++; $display("FAIL reset_port got addr=%0d data=%h expected addr=%0d data=0", fb_address, fb_writedata, BASE);
    end
`ifdef FB_FRAME_CNT_EN
    checks++;
    if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count got %0d expected 0", frame_count); end
`endif
    reset_n = 1'b1;
    #1;
    checks++;
    if (pix_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b expected 1", pix_ready); end
    m_count = 0; m_word = 0;
  endtask

  task automatic test_alt_word;
    int unsigned acc;
    wr_t w;
    for (int i = 0; i < 31; i++) send_pixel(1'(i % 2 == 0), 1'b0, 1'b0);
    acc = cyc + 1;
    send_pixel(1'b0, 1'b0, 1'b0);
    idle(4);
    w.addr = BASE; w.data = 32'h5555_5555; w.cyc = acc;
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL alt_count got %0d writes expected 1", obs_q.size());
    end else if (obs_q[0] !== w) begin
      errors++; $display("FAIL alt_write got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                         obs_q[0].addr, obs_q[0].data, obs_q[0].cyc, w.addr, w.data, w.cyc);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_full_frame;
    for (int i = 0; i < WORDS * 32; i++) send_pixel(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) send_pixel(1'b0, 1'b0, 1'b1);
    idle(3);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++; $display("FAIL frame_count got %0d extra expected %0d more", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL frame_write got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                             o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  endtask

  task automatic test_sof_realign;
    for (int i = 0; i < 40; i++) send_pixel(1'b1, 1'b0, 1'b0);
    send_pixel(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 31; i++) send_pixel(1'b1, 1'b0, 1'b1);
    idle(3);
    checks++;
    if (obs_q.size() != 2 || obs_q[1].addr !== BASE || obs_q[1].data !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL sof_last got %0d writes (last addr=%0d data=%h) expected 2 writes ending addr=%0d data=fffffffe",
                         obs_q.size(), obs_q[obs_q.size()-1].addr, obs_q[obs_q.size()-1].data, BASE);
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++; $display("FAIL sof_count got %0d extra expected %0d more", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL sof_write got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                             o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  endtask

  task automatic test_random_frames;
    for (int i = 0; i < 2000; i++) send_pixel(1'($urandom), 1'($urandom_range(0, 99) == 0), 1'b1);
    idle(3);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++; $display("FAIL random_count got %0d extra expected %0d more", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL random_write got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                             o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  endtask

  task automatic test_clear_mid;
    int n;
    send_pixel(1'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_pixel(1'($urandom), 1'b0, 1'b0);
    pix_valid = 1'b1; pix_data = 1'b1; clear_req = 1'b1;
    #1;
    checks++;
    if (pix_ready !== 1'b0) begin errors++; $display("FAIL clear_ready got %b expected 0", pix_ready); end
    model_clear(cyc + 1);
    @(negedge clk);
    clear_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < WORDS + 20) begin
      pix_valid = 1'($urandom); pix_data = 1'($urandom);
      clear_req = (n == 3);
      n++;
      @(negedge clk);
    end
    pix_valid = 1'b0; clear_req = 1'b0;
    checks++;
    if (n != WORDS + 1) begin errors++; $display("FAIL clear_busy got %0d busy cycles expected %0d", n, WORDS + 1); end
    for (int i = 0; i < 32; i++) send_pixel(1'($urandom), 1'b0, 1'b1);
    idle(3);
    checks++;
    if (obs_done.size() != 1 || exp_done.size() != 1 || obs_done[0] != exp_done[0]) begin
      errors++; $display("FAIL clear_done got %0d pulses first=%0d expected 1 pulse at %0d",
                         obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : 0, exp_done[0]);
    end
    obs_done.delete(); exp_done.delete();
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++; $display("FAIL clear_count got %0d extra expected %0d more", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL clear_write got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                             o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    for (int i = 0; i < 32; i++) send_pixel(1'($urandom), 1'b0, 1'b0);
    clear_req = 1'b1;
    model_clear(cyc + 1);
    @(negedge clk);
    clear_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < WORDS + 20) begin n++; @(negedge clk); end
    idle(3);
    checks++;
    if (obs_done.size() != 1 || obs_done[0] != exp_done[0]) begin
      errors++; $display("FAIL b2b_done got %0d pulses first=%0d expected 1 pulse at %0d",
                         obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : 0, exp_done[0]);
    end
    obs_done.delete(); exp_done.delete();
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++; $display("FAIL b2b_count got %0d extra expected %0d more", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL b2b_write got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                             o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  endtask

  task automatic test_reset_mid_clear;
    int n;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    n = 0;
    while (!(fb_write === 1'b1 && fb_address === 15'(BASE + 10)) && n < 100) begin n++; @(negedge clk); end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL rst_wait got timeout expected address %0d", BASE + 10); end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if (fb_write !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_abort got write=%b busy=%b expected 0 0", fb_write, busy);
    end
`ifdef FB_FRAME_CNT_EN
    checks++;
    if (frame_count !== 16'd0) begin errors++; $display("FAIL rst_frame_count got %0d expected 0", frame_count); end
`endif
    idle(WORDS + 8);
    checks++;
    if (obs_done.size() != 0 || obs_q.size() != 11) begin
      errors++; $display("FAIL rst_writes got %0d writes %0d done pulses expected 11 writes 0 pulses", obs_q.size(), obs_done.size());
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].addr !== 15'(BASE + i) || obs_q[i].data !== CLR) begin
        errors++; $display("FAIL rst_clear_word got addr=%0d data=%h expected addr=%0d data=%h", obs_q[i].addr, obs_q[i].data, BASE + i, CLR);
      end
    end
    obs_q.delete(); obs_done.delete();
    m_count = 0; m_word = 0;
    for (int i = 0; i < 32; i++) send_pixel(1'($urandom), 1'b0, 1'b1);
    idle(3);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      checks++;
      if (exp_q.size() == 0 || obs_q.size() == 0) begin
        errors++; $display("FAIL rst_count got %0d extra expected %0d more", obs_q.size(), exp_q.size());
        exp_q.delete(); obs_q.delete();
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL rst_resume got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                             o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_alt_word;
    test_full_frame;
    test_sof_realign;
    test_random_frames;
    test_clear_mid;
    test_back_to_back;
    test_reset_mid_clear;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
